// File: rtl/mp_serial_addsub_pkg.sv
// mp_pkg: shared state encoding, width defaults and sizing helper
// for the chunk-serial multi-precision adder/subtractor.
package mp_pkg;
    localparam int MP_W = 514;
    localparam int MP_CHUNK = 128;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/mp_chunk_add.sv
// mp_chunk_add: combinational CHUNK-bit adder; the single arithmetic
// element of the serial datapath, kept separate so it can be swapped.
module mp_chunk_add #(
    parameter int CHUNK = 128
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/mp_serial_addsub.sv
// mp_serial_addsub: chunk-serial W-bit add/subtract with start/busy/done
// handshake; one CHUNK-bit slice per cycle through a registered carry.
module mp_serial_addsub
    import mp_pkg::*;
#(
    parameter int W = MP_W,
    parameter int CHUNK = MP_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W:0]   result,
    output logic         done,
    output logic         busy
);
    localparam int NCHUNK = ceil_div(W + 1, CHUNK);
    localparam int PW = NCHUNK * CHUNK;
    localparam int CW = $clog2(NCHUNK + 1);

    state_t            state;
    logic [PW-1:0]     a_sr, b_sr, sum_sr, sum_next, b_ext;
    logic [CHUNK-1:0]  csum;
    logic              carry, cout, last;
    logic [CW-1:0]     cnt;

    mp_chunk_add #(.CHUNK(CHUNK)) u_add (
        .a(a_sr[CHUNK-1:0]),
        .b(b_sr[CHUNK-1:0]),
        .cin(carry),
        .sum(csum),
        .cout(cout)
    );

    assign b_ext = {{(PW-W){1'b0}}, B};
    // Fresh chunk enters at the top, so after NCHUNK shifts the sum is aligned.
    assign sum_next = PW'({csum, sum_sr} >> CHUNK);
    assign last = cnt == CW'(NCHUNK - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= {{(PW-W){1'b0}}, A};
                    b_sr  <= subtract ? ~b_ext : b_ext;
                    carry <= subtract;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr   <= a_sr >> CHUNK;
                    b_sr   <= b_sr >> CHUNK;
                    sum_sr <= sum_next;
                    carry  <= cout;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result <= sum_next[W:0];
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_serial_addsub.sv
// tb_mp_serial_addsub: random and directed checks of the serial adder
// against plain wide-integer arithmetic, default and W=8/CHUNK=3 builds.
module tb_mp_serial_addsub;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, subtract = 1'b0;
    logic [513:0] A = '0, B = '0;
    logic [514:0] result;
    logic         done, busy;
    logic         sstart = 1'b0, ssub = 1'b0;
    logic [7:0]   sa = '0, sb = '0;
    logic [8:0]   sres;
    logic         sdone, sbusy;
    logic [514:0] last_exp = '0;
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    mp_serial_addsub dut (
        .clk(clk), .rst(rst), .start(start), .subtract(subtract),
        .A(A), .B(B), .result(result), .done(done), .busy(busy)
    );

    mp_serial_addsub #(.W(8), .CHUNK(3)) dut_s (
        .clk(clk), .rst(rst), .start(sstart), .subtract(ssub),
        .A(sa), .B(sb), .result(sres), .done(sdone), .busy(sbusy)
    );

    task automatic chk(input string tag, input logic [514:0] got, input logic [514:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [514:0] model(input logic [513:0] a, input logic [513:0] b, input logic s);
        return s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [513:0] rnd514();
        logic [543:0] v = '0;
        logic [513:0] one = 514'd1;
        for (int i = 0; i < 17; i++) v = {v[511:0], $urandom()};
        case ($urandom_range(0, 3))
            0: return v[513:0];
            1: return '1;
            2: return one << $urandom_range(0, 513);
            default: return v[513:0] >> $urandom_range(0, 513);
        endcase
    endfunction

    task automatic big_op(input logic [513:0] a, input logic [513:0] b, input logic s, input logic poke);
        logic [514:0] e = model(a, b, s);
        int k = 0;
        @(negedge clk);
        A = a; B = b; subtract = s; start = 1'b1;
        @(posedge clk); #1;
        while (!done && k < 20) begin
            chk("busy_run", busy, 1);
            chk("hold", result, last_exp);
            start = poke && k == 1;
            if (start) begin A = ~a; B = a; subtract = ~s; end
            @(posedge clk); #1 k++;
        end
        start = 1'b0;
        chk("latency", k, 5);
        chk("result", result, e);
        chk("busy_done", busy, 1);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("result_held", result, e);
        last_exp = e;
    endtask

    task automatic small_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [8:0] e = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        int k = 0;
        @(negedge clk);
        sa = a; sb = b; ssub = s; sstart = 1'b1;
        @(posedge clk); #1 sstart = 1'b0;
        while (!sdone && k < 10) begin
            @(posedge clk); #1 k++;
        end
        chk("s_latency", k, 3);
        chk("s_result", {506'd0, sres}, {506'd0, e});
        @(posedge clk); #1;
        chk("s_done_pulse", sdone, 0);
    endtask

    initial begin
        logic [513:0] ones = '1;
        logic [513:0] c128 = (514'd1 << 128) - 1;
        logic [513:0] p256 = 514'd1 << 256;
        #1;
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sres", {506'd0, sres}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        big_op(ones, 514'd1, 1'b0, 1'b0);
        chk("carry_bit", result[514], 1);
        big_op(514'd5, 514'd7, 1'b1, 1'b0);
        chk("borrow_bit", result[514], 1);
        big_op(c128, c128, 1'b0, 1'b0);
        big_op(p256, 514'd1, 1'b1, 1'b0);
        chk("no_borrow", result[514], 0);
        big_op(rnd514(), rnd514(), 1'b0, 1'b1);
        big_op(rnd514(), rnd514(), 1'b1, 1'b1);
        // abort in the third RUN cycle
        @(negedge clk);
        A = rnd514(); B = rnd514(); subtract = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        last_exp = '0;
        for (int i = 0; i < 20; i++) big_op(rnd514(), rnd514(), 1'($urandom()), 1'($urandom()));
        foreach (sa[i]) begin end
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a += 51)
                for (int b = 0; b < 256; b += 51) begin
                    small_op(8'(a), 8'(b), 1'(s));
                    small_op(8'(255 - a), 8'(b), 1'(s));
                end
        for (int i = 0; i < 800; i++)
            small_op(8'($urandom()), 8'($urandom()), 1'($urandom()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
